multichan_decimator: RTL and testbench
======================================

Name: multichan_decimator

Overview:
Parametrised successor to the single-channel fixed-ratio downsampler that follows the receiver in the transmitter/receiver chain.
- Decimates NUM_CH parallel signed sample streams by a runtime-programmable factor M, with a programmable output phase.
- Uses a valid-qualified input and a single-cycle out_valid strobe.
- Sits between the receiver output and the symbol slicer; all channels share one sample counter.

Parameters:
DATA_W, 16, width of one signed sample per channel
NUM_CH, 2, number of parallel channels packed in in_data/out_data (channel 0 in LSBs)
CNT_W, 4, width of factor/phase inputs and of the sample counter (M max = 2^CNT_W - 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  in_data carries a new sample set this cycle
in_data  in  NUM_CH*DATA_W  packed signed input samples
factor  in  CNT_W  decimation factor M; 0 and 1 both mean pass-through
phase  in  CNT_W  index within the M-window at which the output is taken
sync  in  1  single-cycle: load factor/phase into shadow regs and restart the counter
out_valid  out  1  single-cycle strobe: out_data updated this cycle
out_data  out  NUM_CH*DATA_W  packed signed decimated samples, held between strobes
out_count  out  16  number of out_valid strobes since reset/sync, wraps at 2^16

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_count=0, cnt=0.
  - Shadow M_s=1, P_s=0, so the block is pass-through until the first sync.
- Shadow regs:
  - factor/phase are used only via M_s/P_s, which load on a clock edge where sync=1.
  - Mid-window port changes have no effect.
- Effective values:
  - M_eff = (M_s<2) ? 1 : M_s.
  - P_eff = (P_s>=M_eff) ? M_eff-1 : P_s (clamped, never out of range).
- Counter:
  - cnt advances only on in_valid=1: cnt <= (cnt==M_eff-1) ? 0 : cnt+1.
  - cnt is held when in_valid=0; gaps in in_valid are transparent.
- Sync:
  - cnt <= 0; M_s/P_s loaded; out_count <= 0.
  - If in_valid=1 in the same cycle, that sample is index 0 of the new window and is evaluated against the newly loaded values. The new values take effect for the current sample.
  - out_data is not cleared by sync.
- Capture:
  - Condition: in_valid=1 and index==P_eff, where index is 0 on a sync cycle, else cnt.
  - Registered: out_data <= selected value and out_valid <= 1 on the next edge. Latency 1 clock from the accepted sample.
  - out_count increments with the strobe, except that a capture on a sync cycle gives out_count=1.
- out_valid:
  - High for exactly one cycle per capture.
  - With M_eff=1 and continuous in_valid, out_valid stays high continuously, with a new sample each cycle.
- Channels are processed identically and in lockstep; there is no cross-channel arithmetic.
- Reset mid-operation: immediate return to the reset state; a partially counted window is discarded.

Optional Feature:
Macro: MULTICHAN_DECIMATOR_AVG_EN
- Defined: integrate-and-dump mode.
  - Per-channel signed accumulator of DATA_W+CNT_W bits adds each accepted sample.
  - At a capture, the output is (acc + sample) >>> S, arithmetic shift, truncated to DATA_W, where S = floor(log2(M_eff)). This is an exact mean when M_eff is a power of two.
  - The accumulator clears to 0 on the capture edge, on sync and on reset.
  - The first window after sync is partial (P_eff+1 samples) but uses the same shift.
  - Latency is unchanged at 1 clock.
- Undefined: pick mode. Output is the sample at index P_eff only. No accumulator logic is synthesised.

Test Plan:
- Reset/pass-through: hold reset=0 for 2 cycles, then release and stream ch0=1,2,3… with in_valid=1 → out_valid=0 and out_data=0 during reset; after release, out_data ch0 follows input one cycle late and out_count increments each cycle.
- Decimate by 3, phase 0: sync with factor=3, phase=0, then stream 10,11,12,…,18 → outputs 10,13,16, each one cycle after the sample; out_count=3.
- Phase clamp plus gaps: factor=4, phase=9, with in_valid deasserted every other cycle, stream 0..7 → P_eff=3; outputs 3 and 7 only; out_valid pulses one cycle each.
- Sync collision: mid-stream, assert sync with in_valid=1 on sample 50 and factor=2, phase=0 → 50 is output one cycle later; next output is 52; out_count=1 then 2.
- Multichannel plus async reset: NUM_CH=2, ch0=+k, ch1=−k, factor=2; assert reset between clock edges after 5 samples → channels decimate independently with correct signs; outputs clear immediately without waiting for a clock edge.
- AVG_EN: factor=4, phase=3, stream 4,8,12,16 then −4,−4,−4,−8 → outputs 10 and −5 (arithmetic shift: −20>>>2).

Source files
------------

// File: rtl/multichan_decimator.sv
// -----------------------------------------------------------------------------
// multichan_decimator
//   Decimates NUM_CH parallel signed sample streams by a runtime factor M with
//   a programmable output phase. All channels share one sample counter and the
//   factor/phase shadow registers, so they decimate in lockstep.
//
//   Optional build macro: MULTICHAN_DECIMATOR_AVG_EN
//     defined   -> integrate-and-dump: output is the window sum >>> floor(log2 M)
//     undefined -> pick mode: output is the sample at the phase index
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   in_data carries a new sample set this cycle
//   in_data    NUM_CH packed signed samples, channel 0 in the LSBs
//   factor     decimation factor M (0 and 1 mean pass-through)
//   phase      index within the M-window at which the output is taken
//   sync       load factor/phase into shadow regs and restart the window
//   out_valid  one-cycle strobe, out_data updated this cycle
//   out_data   NUM_CH packed signed decimated samples, held between strobes
//   out_count  number of strobes since reset/sync, wraps at 2^16
// -----------------------------------------------------------------------------
module multichan_decimator #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]         factor,
   input  logic [CNT_W-1:0]         phase,
   input  logic                     sync,
   output logic                     out_valid,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [15:0]              out_count
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   logic [CNT_W-1:0]         m_s;
   logic [CNT_W-1:0]         p_s;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         m_use;
   logic [CNT_W-1:0]         p_use;
   logic [CNT_W-1:0]         m_eff;
   logic [CNT_W-1:0]         p_eff;
   logic [CNT_W-1:0]         index;
   logic [CNT_W-1:0]         cnt_next;
   logic                     capture;
   logic [NUM_CH*DATA_W-1:0] cap_data;

   // On a sync cycle the freshly presented factor/phase govern the current
   // sample, which is index 0 of the new window.
   always_comb begin
      m_use    = sync ? factor : m_s;
      p_use    = sync ? phase  : p_s;
      m_eff    = (m_use < TWO) ? ONE : m_use;
      p_eff    = (p_use >= m_eff) ? (m_eff - ONE) : p_use;
      index    = sync ? '0 : cnt;
      cnt_next = (index == (m_eff - ONE)) ? '0 : (index + ONE);
      capture  = in_valid && (index == p_eff);
   end

`ifdef MULTICHAN_DECIMATOR_AVG_EN
   localparam int unsigned ACC_W = DATA_W + CNT_W;

   logic [CNT_W-1:0]        shift;
   logic signed [ACC_W-1:0] acc     [NUM_CH];
   logic signed [ACC_W-1:0] sum     [NUM_CH];
   logic signed [ACC_W-1:0] shifted [NUM_CH];

   // Sum includes the current sample so the dump happens with no extra latency;
   // a sync cycle starts from an empty accumulator.
   always_comb begin
      shift    = '0;
      cap_data = '0;
      for (int unsigned i = 1; i < CNT_W; i++) begin
         if (m_eff[i]) shift = CNT_W'(i);
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         sum[c]     = (sync ? '0 : acc[c])
                    + {{CNT_W{in_data[c*DATA_W + DATA_W - 1]}}, in_data[c*DATA_W +: DATA_W]};
         shifted[c] = sum[c] >>> shift;
         cap_data[c*DATA_W +: DATA_W] = shifted[c][DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else if (in_valid) begin
         for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= capture ? '0 : sum[c];
      end else if (sync) begin
         for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end
   end
`else
   always_comb begin
      cap_data = in_data;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s       <= ONE;
         p_s       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else begin
         if (sync) begin
            m_s <= factor;
            p_s <= phase;
         end

         if (in_valid) begin
            cnt <= cnt_next;
         end else if (sync) begin
            cnt <= '0;
         end

         out_valid <= capture;
         if (capture) out_data <= cap_data;

         if (sync) begin
            out_count <= capture ? 16'd1 : 16'd0;
         end else if (capture) begin
            out_count <= out_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_multichan_decimator.sv
// -----------------------------------------------------------------------------
// tb_multichan_decimator
//   Scoreboard bench for multichan_decimator (DATA_W=16, NUM_CH=2, CNT_W=4).
//   The stimulus process predicts each output from a sample-count model
//   (capture when samples-since-sync mod M == P) and queues it; a monitor on
//   the falling edge pops and compares on every out_valid strobe and checks
//   that out_data holds between strobes.
//   Honours MULTICHAN_DECIMATOR_AVG_EN to predict window means instead of picks.
// -----------------------------------------------------------------------------
module tb_multichan_decimator;

   localparam int unsigned DW = 16;
   localparam int unsigned NC = 2;
   localparam int unsigned CW = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic [NC*DW-1:0] in_data = '0;
   logic [CW-1:0]   factor = '0;
   logic [CW-1:0]   phase = '0;
   logic            sync = 1'b0;
   logic            out_valid;
   logic [NC*DW-1:0] out_data;
   logic [15:0]     out_count;

   multichan_decimator #(
      .DATA_W (DW),
      .NUM_CH (NC),
      .CNT_W  (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .factor    (factor),
      .phase     (phase),
      .sync      (sync),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NC*DW-1:0] data;
      logic [15:0]      count;
   } exp_t;

   exp_t             sbq[$];
   int               checks = 0;
   int               errors = 0;
   logic [NC*DW-1:0] last_data = '0;

   // reference model state
   int     ms, ps, k, ocnt;
   longint sums [NC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [NC*DW-1:0] pk(input int c0, input int c1);
      logic [31:0] a;
      logic [31:0] b;
      a = c0;
      b = c1;
      return {b[15:0], a[15:0]};
   endfunction

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      ms = 1; ps = 0; k = 0; ocnt = 0;
      for (int c = 0; c < NC; c++) sums[c] = 0;
   endtask

   task automatic model_step(input logic v, input logic [NC*DW-1:0] d, input logic s,
                             input logic [CW-1:0] f, input logic [CW-1:0] p);
      int     meff, peff, lg;
      longint val;
      logic [NC*DW-1:0] dd;
      logic [63:0] vv;
      exp_t   e;
      if (!reset) return;
      if (s) begin
         ms = f; ps = p; k = 0; ocnt = 0;
         for (int c = 0; c < NC; c++) sums[c] = 0;
      end
      meff = (ms < 2) ? 1 : ms;
      peff = (ps >= meff) ? meff - 1 : ps;
      if (!v) return;
      dd = d;
      for (int c = 0; c < NC; c++) sums[c] += longint'($signed(dd[c*DW +: DW]));
      if ((k % meff) == peff) begin
         lg = 0;
         while ((2 ** (lg + 1)) <= meff) lg++;
         e.data = '0;
         for (int c = 0; c < NC; c++) begin
`ifdef MULTICHAN_DECIMATOR_AVG_EN
            val = floor_div(sums[c], longint'(2 ** lg));
`else
            val = longint'($signed(dd[c*DW +: DW]));
`endif
            vv = val;
            e.data[c*DW +: DW] = vv[DW-1:0];
         end
         ocnt = (ocnt + 1) % 65536;
         e.count = ocnt[15:0];
         sbq.push_back(e);
         for (int c = 0; c < NC; c++) sums[c] = 0;
      end
      k++;
   endtask

   task automatic drive(input logic r, input logic v, input logic [NC*DW-1:0] d,
                        input logic s, input logic [CW-1:0] f, input logic [CW-1:0] p);
      @(posedge clk);
      #1;
      reset = r; in_valid = v; in_data = d; sync = s; factor = f; phase = p;
      model_step(v, d, s, f, p);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
   endtask

   // monitor: compare on strobes, check hold and reset state otherwise
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         last_data = '0;
         check("reset_valid", 64'(out_valid), 64'd0);
         check("reset_data", 64'(out_data), 64'd0);
         check("reset_count", 64'(out_count), 64'd0);
      end else if (out_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_strobe", 64'(out_valid), 64'd0);
         end else begin
            e = sbq.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_count", 64'(out_count), 64'(e.count));
            last_data = e.data;
         end
      end else begin
         check("hold_data", 64'(out_data), 64'(last_data));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // reset held for 2 cycles while streaming, then pass-through
      drive(1'b0, 1'b1, pk(1, 0), 1'b0, '0, '0);
      drive(1'b0, 1'b1, pk(2, 0), 1'b0, '0, '0);
      for (int i = 3; i <= 8; i++) drive(1'b1, 1'b1, pk(i, 0), 1'b0, '0, '0);
      idle(2);
      @(negedge clk);
      check("pass_count", 64'(out_count), 64'd6);

      // decimate by 3, phase 0: outputs 10,13,16
      drive(1'b1, 1'b1, pk(10, 0), 1'b1, 4'd3, 4'd0);
      for (int i = 11; i <= 18; i++) drive(1'b1, 1'b1, pk(i, 0), 1'b0, '0, '0);
      idle(2);
      @(negedge clk);
      check("dec3_count", 64'(out_count), 64'd3);
      check("dec3_last", 64'(out_data), 64'(pk(16, 0)));

      // factor 4, phase 9 clamps to 3; gaps every other cycle
      drive(1'b1, 1'b0, '0, 1'b1, 4'd4, 4'd9);
      for (int i = 0; i <= 7; i++) begin
         drive(1'b1, 1'b1, pk(i, 0), 1'b0, 4'd15, 4'd15);
         drive(1'b1, 1'b0, pk(99, 0), 1'b0, 4'd15, 4'd15);
      end
      idle(2);
      @(negedge clk);
      check("clamp_count", 64'(out_count), 64'd2);
      check("clamp_last", 64'(out_data), 64'(pk(7, 0)));

      // sync collides with sample 50
      drive(1'b1, 1'b0, '0, 1'b1, 4'd3, 4'd1);
      for (int i = 40; i <= 49; i++) drive(1'b1, 1'b1, pk(i, 0), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(50, 0), 1'b1, 4'd2, 4'd0);
      drive(1'b1, 1'b1, pk(51, 0), 1'b0, '0, '0);
      @(negedge clk);
      check("coll_first", 64'(out_data), 64'(pk(50, 0)));
      check("coll_count1", 64'(out_count), 64'd1);
      drive(1'b1, 1'b1, pk(52, 0), 1'b0, '0, '0);
      idle(1);
      @(negedge clk);
      check("coll_count2", 64'(out_count), 64'd2);
      check("coll_second", 64'(out_data), 64'(pk(52, 0)));

      // two channels with opposite signs, then async reset between edges
      drive(1'b1, 1'b0, '0, 1'b1, 4'd2, 4'd0);
      for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, pk(i, -i), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(6, -6), 1'b0, '0, '0);
      @(negedge clk);
      check("mc_data", 64'(out_data), 64'(pk(5, -5)));
      #2;
      reset = 1'b0;
      sbq.delete();
      model_reset();
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_data", 64'(out_data), 64'd0);
      check("async_count", 64'(out_count), 64'd0);
      drive(1'b0, 1'b0, '0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, 1'b0, '0, '0);

`ifdef MULTICHAN_DECIMATOR_AVG_EN
      // integrate-and-dump: mean of 4,8,12,16 and of -4,-4,-4,-8
      drive(1'b1, 1'b1, pk(4, -4), 1'b1, 4'd4, 4'd3);
      drive(1'b1, 1'b1, pk(8, -8), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(12, -12), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(16, -16), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(-4, 4), 1'b0, '0, '0);
      @(negedge clk);
      check("avg_pos", 64'(out_data), 64'(pk(10, -10)));
      drive(1'b1, 1'b1, pk(-4, 4), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(-4, 4), 1'b0, '0, '0);
      drive(1'b1, 1'b1, pk(-8, 8), 1'b0, '0, '0);
      idle(1);
      @(negedge clk);
      check("avg_neg", 64'(out_data), 64'(pk(-5, 5)));
`endif

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         drive(1'b1,
               ($urandom_range(0, 9) < 7),
               NC*DW'($urandom),
               ($urandom_range(0, 24) == 0),
               CW'($urandom_range(0, 15)),
               CW'($urandom_range(0, 15)));
      end
      idle(3);
      @(negedge clk);
      check("drain_empty", 64'(sbq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
